// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage:
// opcodes, instruction field positions, FSM states and the output bundle.
package operand_fetch_pkg;

  localparam int XLEN  = 32;
  localparam int OPC_W = 6;
  localparam int RA_W  = 5;

  localparam logic [OPC_W-1:0] OP_ADD       = 6'd0;
  localparam logic [OPC_W-1:0] OP_SUB       = 6'd1;
  localparam logic [OPC_W-1:0] OP_MUL       = 6'd2;
  localparam logic [OPC_W-1:0] OP_NOT       = 6'd3;
  localparam logic [OPC_W-1:0] OP_MAX_LEGAL = 6'd3;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_STALL = 2'd2
  } of_state_t;

  typedef struct packed {
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [OPC_W-1:0] opcode;
    logic [RA_W-1:0]  rd;
    logic             illegal;
  } op_bundle_t;

  function automatic logic is_illegal(logic [OPC_W-1:0] op);
    return op > OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/operand_fetch_regfile.sv
// 32x32 register file: two read ports, one write port,
// r0 hardwired to zero, same-cycle write-to-read bypass.
module regfile_32x32
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RA_W-1:0] ra1,
  input  logic [RA_W-1:0] ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] mem [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (we && waddr == ra1) rd1 = wdata;
    if (we && waddr == ra2) rd2 = wdata;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: decodes sources, tracks pending writes,
// stalls on RAW hazards and registers the ALU operand bundle.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             wb_en,
  input  logic [RA_W-1:0]  wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  Rs1,
  output logic [XLEN-1:0]  Rs2,
  output logic [OPC_W-1:0] opcode,
  output logic [RA_W-1:0]  rd,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             illegal
);

  logic [OPC_W-1:0] f_opc;
  logic [RA_W-1:0]  f_rd;
  logic [RA_W-1:0]  f_rs1;
  logic [RA_W-1:0]  f_rs2;
  logic             unused_bits;

  assign f_opc       = instr[OPC_HI:OPC_LO];
  assign f_rd        = instr[RD_HI:RD_LO];
  assign f_rs1       = instr[RS1_HI:RS1_LO];
  assign f_rs2       = instr[RS2_HI:RS2_LO];
  assign unused_bits = ^instr[RS2_LO-1:0];

  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  regfile_32x32 u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_en),
    .waddr (wb_addr),
    .wdata (wb_data),
    .ra1   (f_rs1),
    .ra2   (f_rs2),
    .rd1   (rdata1),
    .rd2   (rdata2)
  );

  of_state_t  state;
  of_state_t  state_n;
  logic [31:0] pending;
  logic [31:0] pending_n;
  op_bundle_t q;
  op_bundle_t d;

  logic busy1;
  logic busy2;
  logic stall;
  logic accept;
  logic keep;
  logic go_hold;
  logic go_stall;

  // A pending source being written back this cycle is bypassed, not stalled.
  assign busy1 = pending[f_rs1] && !(wb_en && wb_addr == f_rs1);
  assign busy2 = pending[f_rs2] && !(wb_en && wb_addr == f_rs2);
  assign stall = instr_valid && (busy1 || busy2);

  assign op_valid    = (state == S_HOLD);
  assign instr_ready = !rst && (!op_valid || op_ready) && !stall;
  assign accept      = instr_valid && instr_ready;
  assign keep        = op_valid && !op_ready;
  assign go_hold     = accept || keep;
  assign go_stall    = !go_hold && stall;

  always_comb begin
    state_n = S_IDLE;
    unique case (1'b1)
      go_hold:  state_n = S_HOLD;
      go_stall: state_n = S_STALL;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Set after clear so a new writer wins over a retiring one.
  always_comb begin
    pending_n = pending;
    if (wb_en)
      pending_n[wb_addr] = 1'b0;
    if (accept && f_rd != '0)
      pending_n[f_rd] = 1'b1;
    pending_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_n;
  end

  always_comb begin
    d.a       = rdata1;
    d.b       = rdata2;
    d.opcode  = f_opc;
    d.rd      = f_rd;
    d.illegal = is_illegal(f_opc);
  end

  always_ff @(posedge clk) begin
    if (rst)         q <= '0;
    else if (accept) q <= d;
  end

  assign Rs1     = q.a;
  assign Rs2     = q.b;
  assign opcode  = q.opcode;
  assign rd      = q.rd;
  assign illegal = q.illegal;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameters SHALL be none; all widths are fixed: data 32 bits, opcode 6 bits, register address 5 bits.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 instr  in  32  instruction word: [31:26] opcode, [25:21] rd, [20:16] rs1, [15:11] rs2, [10:0] ignored.
REQ-005 instr_valid  in  1  instr is presented this cycle.
REQ-006 instr_ready  out  1  block accepts instr this cycle.
REQ-007 wb_en  in  1  write-back strobe from the downstream result stage.
REQ-008 wb_addr  in  5  write-back register index.
REQ-009 wb_data  in  32  write-back value.
REQ-010 Rs1, Rs2  out  32 each  operands to the ALU.
REQ-011 opcode  out  6  operation code to the ALU.
REQ-012 rd  out  5  destination index, carried alongside the operands.
REQ-013 op_valid  out  1  Rs1, Rs2, opcode and rd are valid.
REQ-014 op_ready  in  1  downstream consumes the operand bundle this cycle.
REQ-015 illegal  out  1  the accepted instruction carries opcode > 6'b000011; asserted together with op_valid.

Function
REQ-016 The register file SHALL hold 32 x 32-bit registers, with r0 reading as 0 and writes to r0 discarded.
REQ-017 A write-back with wb_en=1 SHALL update regfile[wb_addr] at the clock edge.
REQ-018 Reads SHALL bypass: if wb_en=1 and wb_addr equals a source index in the same cycle (and the index is non-zero), the operand SHALL be wb_data.
REQ-019 Scoreboard: one pending bit per register; the bit is set when an instruction with rd != 0 is accepted, and cleared when wb_en=1 with a matching wb_addr.
REQ-020 If a clear and a set target the same register in the same cycle, the set SHALL win.
REQ-021 Hazard: stall = instr_valid and (pending[rs1] or pending[rs2]), unless the pending source is being written back this cycle (bypass per REQ-018).
REQ-022 instr_ready SHALL equal (!op_valid or op_ready) and !stall_hazard, and SHALL be combinational.
REQ-023 Accept = instr_valid and instr_ready; on accept, the output register SHALL load operands, opcode, rd and illegal, and op_valid SHALL go to 1 on the next cycle. Latency is 1 cycle.
REQ-024 op_valid and the output bundle SHALL hold stable while op_valid=1 and op_ready=0.
REQ-025 op_valid SHALL clear when op_ready=1 and there is no accept in the same cycle.
REQ-026 Back-to-back throughput SHALL be 1 instruction per cycle when there are no hazards.
REQ-027 Opcodes above 6'b000011 SHALL still be forwarded unchanged, with illegal=1.
REQ-028 The FSM SHALL have three states:
  - IDLE (op_valid=0)
  - HOLD (op_valid=1 and waiting)
  - STALL (hazard present while no bundle is held)
  Transitions follow REQ-021 to REQ-025.

Reset
REQ-029 When rst=1 at an edge, the block SHALL:
  - clear op_valid, illegal and every scoreboard bit;
  - zero Rs1, Rs2, opcode, rd and all registers;
  - enter IDLE.
REQ-030 Reset SHALL override an accept or write-back in the same cycle; any in-flight bundle is dropped.
REQ-031 instr_ready SHALL be 0 while rst=1.

Structure
REQ-032 A shared package SHALL hold:
  - OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_NOT=3 and OP_MAX_LEGAL=3;
  - the instruction field bit positions;
  - the FSM state encoding.
REQ-033 A single sub-module, regfile_32x32, SHALL contain the register storage with 2 read ports, 1 write port, r0 hardwiring and the bypass.

Verification
REQ-034 Write r1=5 and r2=7 via write-back; then issue {ADD, rd=3, rs1=1, rs2=2} with op_ready=1 -> next cycle op_valid=1, Rs1=5, Rs2=7, opcode=0, rd=3, illegal=0.
REQ-035 Issue a write to r3, then immediately issue an instruction reading r3 -> instr_ready=0 until wb_en with wb_addr=3 and wb_data=12 arrives; in that cycle the instruction is accepted and Rs1=12 on the next cycle.
REQ-036 Hold op_ready=0 for 4 cycles with op_valid=1 -> the bundle stays stable and instr_ready=0; raise op_ready together with a new instr_valid -> the new bundle appears on the next cycle with no bubble.
REQ-037 Write-back to r0 with wb_data=0xFFFF_FFFF, then read r0 -> Rs1=0; an instruction with rd=0 never stalls a later reader.
REQ-038 Issue opcode 6'b000101 -> illegal=1 and opcode=5 forwarded.
REQ-039 Assert rst while op_valid=1 and r4 is pending -> next cycle op_valid=0, the scoreboard is clear, and a read of r4 returns 0 without stalling.
